// File: rtl/line_window_3x3.sv
// rtl/line_window_3x3.sv - raster 3x3 neighbourhood generator with two line buffers.
// Optional LINE_WIN_FRAME_DONE_EN adds a frame_done pulse on the last window of a frame.
module line_window_3x3 #(
   parameter int IMG_W = 256,
   parameter int IMG_H = 256
) (
   input  logic                       clk,
   input  logic                       rst,
   input  logic                       in_valid,
   input  logic [7:0]                 pixel_in,
   output logic                       win_valid,
   output logic [71:0]                win,
   output logic [$clog2(IMG_H)-1:0]   center_row,
   output logic [$clog2(IMG_W)-1:0]   center_col
`ifdef LINE_WIN_FRAME_DONE_EN
   ,
   output logic                       frame_done
`endif
);

   localparam int CW = $clog2(IMG_W);
   localparam int RW = $clog2(IMG_H);
   localparam logic [CW-1:0] COL_LAST = CW'(IMG_W - 1);
   localparam logic [RW-1:0] ROW_LAST = RW'(IMG_H - 1);

   logic [CW-1:0] col;
   logic [RW-1:0] row;
   logic [7:0]    line1 [IMG_W];
   logic [7:0]    line2 [IMG_W];
   logic [7:0]    l1_rd;
   logic [7:0]    l2_rd;
   logic          col_last;
   logic          row_last;
   logic          win_ok;

   assign l1_rd    = line1[col];
   assign l2_rd    = line2[col];
   assign col_last = (col == COL_LAST);
   assign row_last = (row == ROW_LAST);
   // A full neighbourhood exists only once two earlier rows and columns of this line are in.
   assign win_ok   = (row >= RW'(2)) && (col >= CW'(2));

   // Line buffers are deliberately not reset; row<2 gating hides stale content.
   always_ff @(posedge clk) begin
      if (rst && in_valid) begin
         line2[col] <= l1_rd;
         line1[col] <= pixel_in;
      end
   end

   always_ff @(posedge clk) begin
      if (!rst) begin
         col        <= '0;
         row        <= '0;
         win        <= '0;
         win_valid  <= 1'b0;
         center_row <= '0;
         center_col <= '0;
      end else begin
         win_valid <= in_valid && win_ok;
         if (in_valid) begin
            win        <= {win[63:48], l2_rd, win[39:24], l1_rd, win[15:0], pixel_in};
            center_row <= row - RW'(1);
            center_col <= col - CW'(1);
            if (col_last) begin
               col <= '0;
               row <= row_last ? '0 : row + RW'(1);
            end else begin
               col <= col + CW'(1);
            end
         end
      end
   end

`ifdef LINE_WIN_FRAME_DONE_EN
   always_ff @(posedge clk) begin
      if (!rst) begin
         frame_done <= 1'b0;
      end else begin
         frame_done <= in_valid && row_last && col_last;
      end
   end
`endif

endmodule

// File: tb/tb_line_window_3x3.sv
// tb/tb_line_window_3x3.sv - randomized bench for line_window_3x3 against a frame-array model.
module tb_line_window_3x3;

   localparam int W  = 8;
   localparam int H  = 6;
   localparam int CW = $clog2(W);
   localparam int RW = $clog2(H);

   logic          clk = 1'b0;
   logic          rst;
   logic          in_valid;
   logic [7:0]    pixel_in;
   logic          win_valid;
   logic [71:0]   win;
   logic [RW-1:0] center_row;
   logic [CW-1:0] center_col;
`ifdef LINE_WIN_FRAME_DONE_EN
   logic          frame_done;
`endif

   line_window_3x3 #(.IMG_W(W), .IMG_H(H)) dut (
      .clk        (clk),
      .rst        (rst),
      .in_valid   (in_valid),
      .pixel_in   (pixel_in),
      .win_valid  (win_valid),
      .win        (win),
      .center_row (center_row),
      .center_col (center_col)
`ifdef LINE_WIN_FRAME_DONE_EN
      ,
      .frame_done (frame_done)
`endif
   );

   always #5 clk = ~clk;

   logic [7:0]  img [H][W];
   int          mr, mc;
   int          vectors = 0;
   int          miscompares = 0;
   int          pulses;
   int          consec;
   int          fd_pulses;
   logic        prev_wv;
   logic [71:0] first_win;
   logic [RW-1:0] first_cr;
   logic [CW-1:0] first_cc;

   // Drives one cycle; the model stores the pixel in its frame image and cuts the window from it.
   task automatic apply(input bit v, input logic [7:0] p);
      logic [71:0] ew;
      bit          ev;
      bit          efd;
      int          er, ec;
      in_valid = v;
      pixel_in = p;
      ew = '0; ev = 1'b0; efd = 1'b0; er = 0; ec = 0;
      if (v) begin
         img[mr][mc] = p;
         ev  = (mr >= 2) && (mc >= 2);
         efd = (mr == H - 1) && (mc == W - 1);
         er  = mr - 1;
         ec  = mc - 1;
         if (ev)
            for (int dr = 0; dr < 3; dr++)
               for (int dc = 0; dc < 3; dc++)
                  ew = {ew[63:0], img[mr - 2 + dr][mc - 2 + dc]};
         mc++;
         if (mc == W) begin
            mc = 0;
            mr = (mr == H - 1) ? 0 : mr + 1;
         end
      end
      @(posedge clk);
      #1;
      vectors++;
      assert (win_valid === ev) else begin
         miscompares++;
         $error("FAIL win_valid observed=%b expected=%b", win_valid, ev);
      end
      if (ev) begin
         vectors++;
         assert (win === ew) else begin
            miscompares++;
            $error("FAIL win observed=%h expected=%h", win, ew);
         end
         vectors++;
         assert (center_row === RW'(er) && center_col === CW'(ec)) else begin
            miscompares++;
            $error("FAIL center observed=(%0d,%0d) expected=(%0d,%0d)", center_row, center_col, er, ec);
         end
      end
`ifdef LINE_WIN_FRAME_DONE_EN
      vectors++;
      assert (frame_done === efd) else begin
         miscompares++;
         $error("FAIL frame_done observed=%b expected=%b", frame_done, efd);
      end
      if (frame_done === 1'b1) fd_pulses++;
`endif
      if (win_valid === 1'b1) begin
         if (pulses == 0) begin
            first_win = win;
            first_cr  = center_row;
            first_cc  = center_col;
         end
         pulses++;
         if (prev_wv === 1'b1) consec++;
      end
      prev_wv = win_valid;
   endtask

   task automatic check_int(input string tag, input int obs, input int exp);
      vectors++;
      assert (obs == exp) else begin
         miscompares++;
         $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
      end
   endtask

   task automatic check_reset_outputs(input string tag);
      vectors++;
      assert (win === 72'h0 && win_valid === 1'b0 && center_row === '0 && center_col === '0) else begin
         miscompares++;
         $error("FAIL %s observed win=%h wv=%b cr=%0d cc=%0d expected all zero",
                tag, win, win_valid, center_row, center_col);
      end
`ifdef LINE_WIN_FRAME_DONE_EN
      vectors++;
      assert (frame_done === 1'b0) else begin
         miscompares++;
         $error("FAIL %s frame_done observed=%b expected=0", tag, frame_done);
      end
`endif
   endtask

   task automatic start_count();
      pulses = 0; consec = 0; fd_pulses = 0; prev_wv = 1'b0;
   endtask

   initial begin
      mr = 0; mc = 0;
      start_count();
      rst = 1'b0; in_valid = 1'b0; pixel_in = 8'h00;
      repeat (2) @(posedge clk);
      #1;
      check_reset_outputs("reset_state");
      rst = 1'b1;

      // Ramp frame, continuous valid
      start_count();
      for (int r = 0; r < H; r++)
         for (int c = 0; c < W; c++)
            apply(1'b1, 8'(r * 8 + c));
      check_int("ramp_pulses", pulses, 24);
      vectors++;
      assert (first_win === 72'h00_01_02_08_09_0A_10_11_12 && first_cr === RW'(1) && first_cc === CW'(1)) else begin
         miscompares++;
         $error("FAIL ramp_first observed=%h (%0d,%0d) expected=00010208090a101112 (1,1)",
                first_win, first_cr, first_cc);
      end
`ifdef LINE_WIN_FRAME_DONE_EN
      check_int("ramp_frame_done", fd_pulses, 1);
`endif

      // Ramp frame with valid toggling every cycle
      start_count();
      for (int i = 0; i < W * H; i++) begin
         apply(1'b1, 8'(i));
         apply(1'b0, 8'($urandom));
      end
      check_int("toggle_pulses", pulses, 24);
      check_int("toggle_consecutive", consec, 0);
      vectors++;
      assert (first_win === 72'h00_01_02_08_09_0A_10_11_12) else begin
         miscompares++;
         $error("FAIL toggle_first observed=%h expected=00010208090a101112", first_win);
      end

      // Two back-to-back random frames
      start_count();
      for (int i = 0; i < 2 * W * H; i++)
         apply(1'b1, 8'($urandom));
      check_int("b2b_pulses", pulses, 48);
`ifdef LINE_WIN_FRAME_DONE_EN
      check_int("b2b_frame_done", fd_pulses, 2);
`endif

      // Random frame with random-length gaps
      start_count();
      for (int i = 0; i < W * H; i++) begin
         apply(1'b1, 8'($urandom));
         repeat ($urandom_range(0, 3)) apply(1'b0, 8'($urandom));
      end
      check_int("gap_pulses", pulses, 24);

      // Mid-frame reset after 20 pixels, then a fresh frame
      for (int i = 0; i < 20; i++)
         apply(1'b1, 8'($urandom));
      rst = 1'b0; in_valid = 1'b1; pixel_in = 8'($urandom);
      mr = 0; mc = 0;
      @(posedge clk);
      #1;
      check_reset_outputs("mid_reset");
      rst = 1'b1;
      start_count();
      for (int i = 0; i < W * H; i++)
         apply(1'b1, 8'($urandom));
      check_int("post_reset_pulses", pulses, 24);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule

// File: doc/line_window_3x3.md
LINE_WINDOW_3X3 -- requirements
Module: line_window_3x3

Interface
REQ-001 SHALL have parameter IMG_W, default 256, pixels per line (min 3).
REQ-002 SHALL have parameter IMG_H, default 256, lines per frame (min 3).
REQ-003 SHALL have port clk  input  1  rising-edge clock.
REQ-004 SHALL have port rst  input  1  reset, synchronous, active-low.
REQ-005 SHALL have port in_valid  input  1  pixel_in qualifier; one raster pixel accepted per cycle when high.
REQ-006 SHALL have port pixel_in  input  8  grey pixel, raster order, row 0 col 0 first.
REQ-007 SHALL have port win_valid  output  1  win holds a complete 3x3 neighbourhood.
REQ-008 SHALL have port win  output  72  window; [71:64]=(r-2,c-2), [63:56]=(r-2,c-1), [55:48]=(r-2,c), [47:40]=(r-1,c-2) ... [7:0]=(r,c); (r,c)=newest accepted pixel.
REQ-009 SHALL have port center_row  output  log2(IMG_H)  row of window centre (r-1).
REQ-010 SHALL have port center_col  output  log2(IMG_W)  column of window centre (c-1).

Function
REQ-011 SHALL keep col counter 0..IMG_W-1 and row counter 0..IMG_H-1, advanced only on accepted pixels.
REQ-012 SHALL wrap col to 0 and increment row after col=IMG_W-1; after (IMG_H-1, IMG_W-1) both SHALL wrap to 0 (next frame).
REQ-013 SHALL hold two line buffers of IMG_W x 8 bits (rows r-1, r-2), read and written at address col on the same accepted cycle (read-before-write).
REQ-014 SHALL hold a 3x3 shift register; each accepted pixel shifts columns left, new right column = {line2[col], line1[col], pixel_in}.
REQ-015 SHALL register win, win_valid, center_row, center_col one cycle after the accepting edge (latency 1).
REQ-016 SHALL assert win_valid for exactly one cycle per accepted pixel with row>=2 and col>=2; otherwise win_valid=0.
REQ-017 SHALL produce (IMG_W-2)*(IMG_H-2) valid windows per frame.
REQ-018 SHALL not take a window across a line boundary: at col 0 and 1 win_valid=0 regardless of shift-register content.
REQ-019 SHALL, with in_valid low, hold counters, buffers, shift register and win; win_valid=0 next cycle.
REQ-020 SHALL support in_valid gaps of any length mid-line without altering the window sequence.

Reset
REQ-021 SHALL, while rst=0 at a clk edge, clear col, row, shift register, win, win_valid, center_row, center_col to 0.
REQ-022 SHALL not clear line-buffer storage; stale content is masked by row<2 gating after reset.
REQ-023 SHALL, on reset mid-frame, restart at (0,0); next pixel is treated as frame start.

Configuration
REQ-024 SHALL, with macro LINE_WIN_FRAME_DONE_EN defined, add output frame_done (1 bit, reset 0) pulsing high one cycle, aligned with win_valid of the (IMG_H-1, IMG_W-1) pixel.
REQ-025 SHALL, without LINE_WIN_FRAME_DONE_EN, omit the frame_done port and logic entirely; all other behaviour identical.

Verification (IMG_W=8, IMG_H=6)
REQ-026 Ramp frame, pixel=row*8+col, continuous in_valid -> 24 win_valid pulses; first win = {00,01,02,08,09,0A,10,11,12}, center (1,1), one cycle after pixel 0x12 accepted.
REQ-027 Same frame with in_valid toggling 1/0 every cycle -> identical 24 windows in same order; win_valid never high two consecutive cycles.
REQ-028 Two back-to-back frames -> 48 pulses; no window from frame 2 before its row 2 col 2; no window mixes frames.
REQ-029 rst=0 for one cycle after 20 pixels, then new frame -> all outputs 0 after reset edge; first window uses only new-frame pixels.
REQ-030 Last-column check: pixel (3,7) accepted -> win_valid, center (2,6); pixel (4,0),(4,1) -> win_valid=0.
REQ-031 LINE_WIN_FRAME_DONE_EN defined -> frame_done single pulse coincident with window centre (4,6); undefined -> port absent, builds clean.
